// File: rtl/path_ctrl_ws_if.sv
// path_ctrl_ws_if -- controller <-> datapath/memory bundle for path_ctrl_ws.
//   master : controller side (drives selects, enables, flags, state_dbg)
//   slave  : datapath side (drives opcode and memory ready)
// Signals:
//   op[5:0]        opcode from instruction register
//   mem_ready      memory completes current access this cycle
//   mem_req/i_or_d memory request and address select
//   ireg_enab, pc_src[1:0], pc_write, branch, branch_ne
//   mem_to_reg, mem_enab, reg_dst, reg_write
//   alu_srcA, alu_srcB[1:0], alu_op[1:0], imm_zext
//   illegal, bus_err (sticky), state_dbg[3:0]
interface path_ctrl_ws_if;
  logic [5:0] op;
  logic       mem_ready;
  logic       mem_req;
  logic       i_or_d;
  logic       ireg_enab;
  logic [1:0] pc_src;
  logic       pc_write;
  logic       branch;
  logic       branch_ne;
  logic       mem_to_reg;
  logic       mem_enab;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_srcA;
  logic [1:0] alu_srcB;
  logic [1:0] alu_op;
  logic       imm_zext;
  logic       illegal;
  logic       bus_err;
  logic [3:0] state_dbg;

  modport master (
    input  op, mem_ready,
    output mem_req, i_or_d, ireg_enab, pc_src, pc_write, branch, branch_ne,
           mem_to_reg, mem_enab, reg_dst, reg_write, alu_srcA, alu_srcB,
           alu_op, imm_zext, illegal, bus_err, state_dbg
  );

  modport slave (
    output op, mem_ready,
    input  mem_req, i_or_d, ireg_enab, pc_src, pc_write, branch, branch_ne,
           mem_to_reg, mem_enab, reg_dst, reg_write, alu_srcA, alu_srcB,
           alu_op, imm_zext, illegal, bus_err, state_dbg
  );
endinterface

// File: rtl/path_ctrl_ws.sv
// path_ctrl_ws -- multicycle MIPS-subset main controller with memory
// wait states, BNE/ANDI/ORI support and illegal-opcode / timeout traps.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-low reset (0 = reset)
//   bus    path_ctrl_ws_if.master: opcode + mem_ready in, all control
//          selects/enables, sticky flags and state_dbg out
// Parameters:
//   MEM_TIMEOUT   consecutive not-ready cycles tolerated in one wait state
//   EN_LOGIC_IMM  1 = ANDI/ORI decoded, 0 = they trap as illegal
module path_ctrl_ws #(
  parameter int MEM_TIMEOUT  = 15,
  parameter int EN_LOGIC_IMM = 1
) (
  input  logic           clk,
  input  logic           reset,
  path_ctrl_ws_if.master bus
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);

  typedef enum logic [3:0] {
    FETCH      = 4'd0,
    DECODE     = 4'd1,
    MEM_ADDR   = 4'd2,
    MEM_READ   = 4'd3,
    MEM_TO_REG = 4'd4,
    MEM_WRITE  = 4'd5,
    EXECUTE    = 4'd6,
    ALU_TO_REG = 4'd7,
    BRANCH     = 4'd8,
    IMM_EXEC   = 4'd9,
    IMM_TO_REG = 4'd10,
    JUMP       = 4'd11,
    TRAP       = 4'd15
  } state_t;

  // fetch_en marks FETCH; the IR/PC load it enables is qualified by
  // mem_ready at the output so it only fires in the completing cycle.
  typedef struct packed {
    logic       mem_req;
    logic       i_or_d;
    logic       fetch_en;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       branch;
    logic       branch_ne;
    logic       mem_to_reg;
    logic       mem_enab;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       imm_zext;
  } ctrl_t;

  // Moore output decode for a state; every field defaults to 0.
  function automatic ctrl_t decode_ctrl(input state_t s, input logic [5:0] opc,
                                        input logic from_imm);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.mem_req   = 1'b1;
        c.fetch_en  = 1'b1;
        c.alu_src_b = 2'b01;
      end
      DECODE: begin
        c.alu_src_b = 2'b11;
      end
      MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      MEM_READ: begin
        c.mem_req = 1'b1;
        c.i_or_d  = 1'b1;
      end
      MEM_TO_REG: begin
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
      end
      MEM_WRITE: begin
        c.mem_req  = 1'b1;
        c.i_or_d   = 1'b1;
        c.mem_enab = 1'b1;
      end
      EXECUTE: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b10;
      end
      ALU_TO_REG: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
      end
      BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b01;
        c.pc_src    = 2'b01;
        c.branch    = (opc == OP_BEQ);
        c.branch_ne = (opc == OP_BNE);
      end
      IMM_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.alu_op    = 2'b11;
        c.imm_zext  = 1'b1;
      end
      IMM_TO_REG: begin
        c.reg_write = 1'b1;
        c.imm_zext  = from_imm;
      end
      JUMP: begin
        c.pc_src   = 2'b10;
        c.pc_write = 1'b1;
      end
      default: begin
        c = '0;
      end
    endcase
    return c;
  endfunction

  state_t      state_r;
  state_t      next_s;
  logic [7:0]  wait_cnt_r;
  logic        illegal_r;
  logic        bus_err_r;
  ctrl_t       ctrl_r;
  logic        set_ill_s;
  logic        set_be_s;
  logic        is_wait_s;
  logic        timeout_s;

  assign is_wait_s = (state_r == FETCH) || (state_r == MEM_READ) || (state_r == MEM_WRITE);
  assign timeout_s = (wait_cnt_r == TIMEOUT_C);

  // Next-state selection and trap-cause detection.
  always_comb begin
    next_s    = state_r;
    set_ill_s = 1'b0;
    set_be_s  = 1'b0;
    case (state_r)
      FETCH, MEM_READ, MEM_WRITE: begin
        // a completing access on the timeout cycle still wins
        if (bus.mem_ready) begin
          if (state_r == FETCH) begin
            next_s = DECODE;
          end else if (state_r == MEM_READ) begin
            next_s = MEM_TO_REG;
          end else begin
            next_s = FETCH;
          end
        end else if (timeout_s) begin
          next_s   = TRAP;
          set_be_s = 1'b1;
        end else begin
          next_s = state_r;
        end
      end
      DECODE: begin
        case (bus.op)
          OP_RTYPE:              next_s = EXECUTE;
          OP_LW, OP_SW, OP_ADDI: next_s = MEM_ADDR;
          OP_BEQ, OP_BNE:        next_s = BRANCH;
          OP_J:                  next_s = JUMP;
          OP_ANDI, OP_ORI: begin
            if (EN_LOGIC_IMM != 0) begin
              next_s = IMM_EXEC;
            end else begin
              next_s    = TRAP;
              set_ill_s = 1'b1;
            end
          end
          default: begin
            next_s    = TRAP;
            set_ill_s = 1'b1;
          end
        endcase
      end
      MEM_ADDR: begin
        // opcode changing under us is treated as illegal rather than guessed
        case (bus.op)
          OP_LW:   next_s = MEM_READ;
          OP_SW:   next_s = MEM_WRITE;
          OP_ADDI: next_s = IMM_TO_REG;
          default: begin
            next_s    = TRAP;
            set_ill_s = 1'b1;
          end
        endcase
      end
      MEM_TO_REG: next_s = FETCH;
      EXECUTE:    next_s = ALU_TO_REG;
      ALU_TO_REG: next_s = FETCH;
      BRANCH:     next_s = FETCH;
      IMM_EXEC:   next_s = IMM_TO_REG;
      IMM_TO_REG: next_s = FETCH;
      JUMP:       next_s = FETCH;
      TRAP:       next_s = TRAP;
      default:    next_s = TRAP;
    endcase
  end

  // State, wait counter, sticky flags and registered output decode.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= FETCH;
      wait_cnt_r <= 8'd0;
      illegal_r  <= 1'b0;
      bus_err_r  <= 1'b0;
      ctrl_r     <= decode_ctrl(FETCH, 6'd0, 1'b0);
    end else begin
      state_r   <= next_s;
      illegal_r <= illegal_r | set_ill_s;
      bus_err_r <= bus_err_r | set_be_s;
      // outputs are registered from next state so they line up with state_r
      ctrl_r    <= decode_ctrl(next_s, bus.op, state_r == IMM_EXEC);
      if (next_s != state_r) begin
        wait_cnt_r <= 8'd0;
      end else if (is_wait_s && !bus.mem_ready) begin
        wait_cnt_r <= wait_cnt_r + 8'd1;
      end else begin
        wait_cnt_r <= 8'd0;
      end
    end
  end

  // Gated enables are also qualified by reset so nothing fires while held.
  assign bus.ireg_enab  = ctrl_r.fetch_en & bus.mem_ready & reset;
  assign bus.pc_write   = (ctrl_r.pc_write | (ctrl_r.fetch_en & bus.mem_ready)) & reset;
  assign bus.mem_req    = ctrl_r.mem_req;
  assign bus.i_or_d     = ctrl_r.i_or_d;
  assign bus.pc_src     = ctrl_r.pc_src;
  assign bus.branch     = ctrl_r.branch;
  assign bus.branch_ne  = ctrl_r.branch_ne;
  assign bus.mem_to_reg = ctrl_r.mem_to_reg;
  assign bus.mem_enab   = ctrl_r.mem_enab;
  assign bus.reg_dst    = ctrl_r.reg_dst;
  assign bus.reg_write  = ctrl_r.reg_write;
  assign bus.alu_srcA   = ctrl_r.alu_src_a;
  assign bus.alu_srcB   = ctrl_r.alu_src_b;
  assign bus.alu_op     = ctrl_r.alu_op;
  assign bus.imm_zext   = ctrl_r.imm_zext;
  assign bus.illegal    = illegal_r;
  assign bus.bus_err    = bus_err_r;
  assign bus.state_dbg  = state_r;

endmodule

// File: tb/tb_path_ctrl_ws.sv
// tb_path_ctrl_ws -- self-checking bench for path_ctrl_ws. A per-instruction
// state-path model (queue of expected states) plus a wait/timeout counter
// predicts state_dbg and every control output each cycle.
module tb_path_ctrl_ws;
  localparam int TMO = 15;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  logic       clk     = 1'b0;
  logic       reset   = 1'b0;
  logic [5:0] op_v    = OP_LW;
  logic       ready_v = 1'b1;

  always #5 clk = ~clk;

  path_ctrl_ws_if if0();
  path_ctrl_ws_if if1();
  assign if0.op        = op_v;
  assign if0.mem_ready = ready_v;
  assign if1.op        = op_v;
  assign if1.mem_ready = ready_v;

  path_ctrl_ws #(.MEM_TIMEOUT(TMO), .EN_LOGIC_IMM(1)) dut0 (.clk(clk), .reset(reset), .bus(if0));
  path_ctrl_ws #(.MEM_TIMEOUT(TMO), .EN_LOGIC_IMM(0)) dut1 (.clk(clk), .reset(reset), .bus(if1));

  logic [19:0] obs0;
  assign obs0 = {if0.mem_req, if0.i_or_d, if0.ireg_enab, if0.pc_src, if0.pc_write,
                 if0.branch, if0.branch_ne, if0.mem_to_reg, if0.mem_enab, if0.reg_dst,
                 if0.reg_write, if0.alu_srcA, if0.alu_srcB, if0.alu_op, if0.imm_zext,
                 if0.illegal, if0.bus_err};

  int         total = 0;
  int         bad   = 0;
  int         m_state = 0;
  int         m_wait  = 0;
  logic       m_ill = 1'b0;
  logic       m_be  = 1'b0;
  int         m_q[$];
  logic [5:0] ops [9] = '{OP_R, OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_ORI, OP_LW, OP_SW};
  logic [5:0] rop;
  logic       rr;
  int         pick;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Expected control outputs for a state, straight from the state table.
  function automatic logic [19:0] exp_out(input int s, input logic [5:0] o, input logic r,
                                          input logic ill, input logic be);
    logic mreq, iord, ireg, pcw, br, brne, m2r, men, rdst, rw, sa, zx;
    logic [1:0] pcs, sb, aop;
    {mreq, iord, ireg, pcw, br, brne, m2r, men, rdst, rw, sa, zx} = 12'd0;
    pcs = 2'b00; sb = 2'b00; aop = 2'b00;
    case (s)
      0:  begin mreq = 1'b1; sb = 2'b01; ireg = r; pcw = r; end
      1:  sb = 2'b11;
      2:  begin sa = 1'b1; sb = 2'b10; end
      3:  begin mreq = 1'b1; iord = 1'b1; end
      4:  begin m2r = 1'b1; rw = 1'b1; end
      5:  begin mreq = 1'b1; iord = 1'b1; men = 1'b1; end
      6:  begin sa = 1'b1; aop = 2'b10; end
      7:  begin rdst = 1'b1; rw = 1'b1; end
      8:  begin sa = 1'b1; aop = 2'b01; pcs = 2'b01; br = (o == OP_BEQ); brne = (o == OP_BNE); end
      9:  begin sa = 1'b1; sb = 2'b10; aop = 2'b11; zx = 1'b1; end
      10: begin rw = 1'b1; zx = (o == OP_ANDI) || (o == OP_ORI); end
      11: begin pcs = 2'b10; pcw = 1'b1; end
      default: ;
    endcase
    return {mreq, iord, ireg, pcs, pcw, br, brne, m2r, men, rdst, rw, sa, sb, aop, zx, ill, be};
  endfunction

  // States an instruction walks through after FETCH completes.
  task automatic load_path(input logic [5:0] o);
    m_q.delete();
    m_q.push_back(1);
    case (o)
      OP_R:            begin m_q.push_back(6); m_q.push_back(7); end
      OP_J:            m_q.push_back(11);
      OP_BEQ, OP_BNE:  m_q.push_back(8);
      OP_ADDI:         begin m_q.push_back(2); m_q.push_back(10); end
      OP_ANDI, OP_ORI: begin m_q.push_back(9); m_q.push_back(10); end
      OP_LW:           begin m_q.push_back(2); m_q.push_back(3); m_q.push_back(4); end
      OP_SW:           begin m_q.push_back(2); m_q.push_back(5); end
      default:         m_q.push_back(15);
    endcase
  endtask

  task automatic model_adv(input logic [5:0] o, input logic r);
    if (m_state == 15) begin
      m_state = 15;
    end else if ((m_state == 0 || m_state == 3 || m_state == 5) && !r) begin
      if (m_wait == TMO) begin
        m_state = 15; m_be = 1'b1; m_wait = 0;
      end else begin
        m_wait++;
      end
    end else begin
      m_wait = 0;
      if (m_state == 0) load_path(o);
      if (m_q.size() == 0) begin
        m_state = 0;
      end else begin
        m_state = m_q.pop_front();
        if (m_state == 15) m_ill = 1'b1;
      end
    end
  endtask

  // Called at a negedge: apply inputs, check, advance model, wait next negedge.
  task automatic step(input logic [5:0] o, input logic r);
    op_v = o; ready_v = r;
    #1;
    chk("state", 32'(if0.state_dbg), 32'(m_state));
    chk("outs", 32'(obs0), 32'(exp_out(m_state, o, r, m_ill, m_be)));
    model_adv(o, r);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0; ready_v = 1'b1;
    #1;
    chk("rst_state", 32'(if0.state_dbg), 32'd0);
    chk("rst_outs", 32'(obs0), 32'(exp_out(0, op_v, 1'b0, 1'b0, 1'b0)));
    @(negedge clk);
    reset = 1'b1;
    m_state = 0; m_wait = 0; m_ill = 1'b0; m_be = 1'b0; m_q.delete();
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    // LW, zero wait: 0,1,2,3,4
    repeat (5) step(OP_LW, 1'b1);
    // FETCH stalled three cycles, then RTYPE
    repeat (3) step(OP_R, 1'b0);
    repeat (4) step(OP_R, 1'b1);
    repeat (3) step(OP_BNE, 1'b1);
    repeat (3) step(OP_BEQ, 1'b1);
    repeat (4) step(OP_ORI, 1'b1);
    // logic-immediate disabled instance must have trapped on ORI
    chk("noimm_state", 32'(if1.state_dbg), 32'd15);
    chk("noimm_illegal", 32'(if1.illegal), 32'd1);
    chk("noimm_regwrite", 32'(if1.reg_write), 32'd0);
    repeat (3) step(OP_J, 1'b1);
    repeat (4) step(OP_ADDI, 1'b1);
    repeat (4) step(OP_ANDI, 1'b1);
    repeat (4) step(OP_SW, 1'b1);
    step(OP_LW, 1'b1);
    repeat (2) step(OP_LW, 1'b0);
    repeat (2) step(OP_LW, 1'b1);
    repeat (3) step(OP_LW, 1'b0);
    repeat (4) step(OP_LW, 1'b1);

    // randomized instruction mix with random memory wait states
    for (int i = 0; i < 400; i++) begin
      if (m_state == 15) begin
        step(op_v, 1'b1);
        do_reset();
      end else begin
        rop = op_v;
        if (m_state == 0) begin
          pick = $urandom_range(0, 19);
          if (pick < 19) rop = ops[pick % 9];
          else rop = 6'($urandom_range(0, 63));
        end
        rr = ($urandom_range(0, 3) != 0);
        step(rop, rr);
      end
    end

    // ready on the timeout cycle completes normally
    do_reset();
    repeat (3) step(OP_SW, 1'b1);
    repeat (TMO) step(OP_SW, 1'b0);
    step(OP_SW, 1'b1);
    chk("tmo_edge_state", 32'(if0.state_dbg), 32'd0);

    // SW held not-ready until bus error
    do_reset();
    repeat (3) step(OP_SW, 1'b1);
    repeat (TMO + 3) step(OP_SW, 1'b0);
    chk("be_flag", 32'(if0.bus_err), 32'd1);
    chk("be_menab", 32'(if0.mem_enab), 32'd0);
    chk("be_state", 32'(if0.state_dbg), 32'd15);
    do_reset();

    // async reset in the middle of MEM_WRITE
    repeat (3) step(OP_SW, 1'b1);
    step(OP_SW, 1'b0);
    #2;
    chk("ar_menab_pre", 32'(if0.mem_enab), 32'd1);
    reset = 1'b0;
    #1;
    chk("ar_menab", 32'(if0.mem_enab), 32'd0);
    chk("ar_state", 32'(if0.state_dbg), 32'd0);
    @(negedge clk);
    do_reset();
    repeat (5) step(OP_LW, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
